mem_stage_lsu: RTL and testbench

- Memory-stage load/store sequencer for the e5rv32 pipeline; consumes the M-stage control bundle (ResultSrcM, RegWriteM, FRegWriteM, MemWriteM) plus the datapath values, and issues load/store requests on a req/ready data-memory port.
- Stalls the upstream pipeline while an access is outstanding and produces the M->W register contents, inserting bubbles into W until the access completes.

---
 rtl/e5_pkg.sv | 38 +++
 rtl/mem_stage_lsu_mw_reg.sv | 44 ++++
 rtl/mem_stage_lsu.sv | 171 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/e5_pkg.sv
// e5_pkg: shared types for the e5rv32 memory stage.
//   lsu_state_t : load/store sequencer states (CLEAR, IDLE, WAIT)
//   m_ctrl_t    : M-stage control bundle (includes memWrite)
//   w_ctrl_t    : W-stage control bundle
//   XLEN_DEF    : default datapath width
package e5_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2
  } lsu_state_t;

  typedef struct packed {
    logic resultSrc;
    logic regWrite;
    logic fRegWrite;
    logic memWrite;
  } m_ctrl_t;

  typedef struct packed {
    logic resultSrc;
    logic regWrite;
    logic fRegWrite;
  } w_ctrl_t;

  // Drop the store bit when an M bundle moves into W.
  function automatic w_ctrl_t toWCtrl(input m_ctrl_t c);
    w_ctrl_t w;
    w.resultSrc = c.resultSrc;
    w.regWrite  = c.regWrite;
    w.fRegWrite = c.fRegWrite;
    return w;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_mw_reg.sv
// mw_reg: M->W pipeline register with a bubble input.
//   clk, reset      : falling-edge clock, async active-low reset
//   bubble          : load an all-zero bundle instead of the D inputs
//   ctrlD/readDataD/aluResultD/rdD : next W contents
//   ctrlQ/readDataQ/aluResultQ/rdQ : registered W contents
// Also used by the non-memory writeback path.
module mw_reg
  import e5_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bubble,
  input  w_ctrl_t         ctrlD,
  input  logic [XLEN-1:0] readDataD,
  input  logic [XLEN-1:0] aluResultD,
  input  logic [4:0]      rdD,
  output w_ctrl_t         ctrlQ,
  output logic [XLEN-1:0] readDataQ,
  output logic [XLEN-1:0] aluResultQ,
  output logic [4:0]      rdQ
);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      ctrlQ      <= '0;
      readDataQ  <= '0;
      aluResultQ <= '0;
      rdQ        <= '0;
    end else if (bubble) begin
      ctrlQ      <= '0;
      readDataQ  <= '0;
      aluResultQ <= '0;
      rdQ        <= '0;
    end else begin
      ctrlQ      <= ctrlD;
      readDataQ  <= readDataD;
      aluResultQ <= aluResultD;
      rdQ        <= rdD;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store sequencer for e5rv32.
//   clk, reset            : falling-edge pipeline clock, async active-low reset
//   ResultSrcM..RdM       : M-stage controls and datapath values
//   mem_req/we/addr/wdata : data-memory request (held until mem_ready)
//   mem_ready/mem_rdata   : one-cycle completion pulse and load data
//   StallM                : freezes F/D/E/M while an access is outstanding
//   *W                    : M->W register contents (bubbles while waiting)
//   mem_err               : sticky timeout flag, cleared only by reset
// A request is issued combinationally from IDLE; a same-cycle ready completes
// it without stalling. Otherwise the fields are latched and held in WAIT until
// ready or until the wait counter hits TIMEOUT, which abandons the access and
// lets the pipeline advance past the faulting instruction with no writeback.
module mem_stage_lsu
  import e5_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ResultSrcM,
  input  logic            RegWriteM,
  input  logic            FRegWriteM,
  input  logic            MemWriteM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [4:0]      RdM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            StallM,
  output logic            ResultSrcW,
  output logic            RegWriteW,
  output logic            FRegWriteW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [4:0]      RdW,
  output logic            mem_err
);

  localparam logic [3:0] TO_CNT = 4'(TIMEOUT);

  lsu_state_t      state, nextState;
  logic [3:0]      cnt;
  m_ctrl_t         mCtrl, lCtrl;
  logic [XLEN-1:0] lAddr, lWdata;
  logic [4:0]      lRd;
  logic            access, latchReq, timeout;

  logic            wBubble;
  w_ctrl_t         wCtrlD, wCtrlQ;
  logic [XLEN-1:0] wReadD, wAluD;
  logic [4:0]      wRdD;

  assign mCtrl  = '{resultSrc: ResultSrcM, regWrite: RegWriteM,
                    fRegWrite: FRegWriteM, memWrite: MemWriteM};
  assign access = MemWriteM | ResultSrcM;

  always_comb begin
    nextState = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    StallM    = 1'b0;
    latchReq  = 1'b0;
    timeout   = 1'b0;
    wBubble   = 1'b1;
    wCtrlD    = '0;
    wReadD    = '0;
    wAluD     = '0;
    wRdD      = '0;
    case (state)
      CLEAR: nextState = IDLE;
      IDLE: begin
        if (!access) begin
          wBubble = 1'b0;
          wCtrlD  = toWCtrl(mCtrl);
          wAluD   = ALUResultM;
          wRdD    = RdM;
        end else begin
          mem_req   = 1'b1;
          mem_we    = MemWriteM;
          mem_addr  = ALUResultM;
          mem_wdata = WriteDataM;
          if (mem_ready) begin
            wBubble = 1'b0;
            wCtrlD  = toWCtrl(mCtrl);
            wReadD  = ResultSrcM ? mem_rdata : '0;
            wAluD   = ALUResultM;
            wRdD    = RdM;
          end else begin
            StallM    = 1'b1;
            latchReq  = 1'b1;
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_ready) begin
          // ready wins over a coincident timeout
          mem_req   = 1'b1;
          mem_we    = lCtrl.memWrite;
          mem_addr  = lAddr;
          mem_wdata = lWdata;
          wBubble   = 1'b0;
          wCtrlD    = toWCtrl(lCtrl);
          wReadD    = lCtrl.resultSrc ? mem_rdata : '0;
          wAluD     = lAddr;
          wRdD      = lRd;
          nextState = IDLE;
        end else if (cnt == TO_CNT) begin
          // abandon: request and stall drop, W gets a bubble
          timeout   = 1'b1;
          nextState = IDLE;
        end else begin
          mem_req   = 1'b1;
          mem_we    = lCtrl.memWrite;
          mem_addr  = lAddr;
          mem_wdata = lWdata;
          StallM    = 1'b1;
        end
      end
      default: nextState = CLEAR;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      cnt     <= '0;
      mem_err <= 1'b0;
      lCtrl   <= '0;
      lAddr   <= '0;
      lWdata  <= '0;
      lRd     <= '0;
    end else begin
      state <= nextState;
      cnt   <= (state == WAIT && nextState == WAIT) ? cnt + 4'd1 : 4'd0;
      if (timeout) mem_err <= 1'b1;
      if (latchReq) begin
        lCtrl  <= mCtrl;
        lAddr  <= ALUResultM;
        lWdata <= WriteDataM;
        lRd    <= RdM;
      end
    end
  end

  mw_reg #(.XLEN(XLEN)) uMwReg (
    .clk        (clk),
    .reset      (reset),
    .bubble     (wBubble),
    .ctrlD      (wCtrlD),
    .readDataD  (wReadD),
    .aluResultD (wAluD),
    .rdD        (wRdD),
    .ctrlQ      (wCtrlQ),
    .readDataQ  (ReadDataW),
    .aluResultQ (ALUResultW),
    .rdQ        (RdW)
  );

  assign ResultSrcW = wCtrlQ.resultSrc;
  assign RegWriteW  = wCtrlQ.regWrite;
  assign FRegWriteW = wCtrlQ.fRegWrite;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu. Inputs change 1ns after each falling
// edge; combinational outputs are sampled on the rising edge and W registers
// 1ns after the falling edge. Expected W contents are queued when a cycle is
// driven and popped once the edge has passed.
module tb_mem_stage_lsu;

  logic        clk, reset;
  logic        ResultSrcM, RegWriteM, FRegWriteM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  RdM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        StallM, ResultSrcW, RegWriteW, FRegWriteW;
  logic [31:0] ReadDataW, ALUResultW;
  logic [4:0]  RdW;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rs;
    logic        rw;
    logic        frw;
    logic [31:0] rdat;
    logic [31:0] alu;
    logic [4:0]  rd;
  } wexp_t;

  wexp_t sb[$];
  localparam wexp_t BUB = '0;

  mem_stage_lsu #(.XLEN(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM), .FRegWriteM(FRegWriteM),
    .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallM(StallM), .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW),
    .FRegWriteW(FRegWriteW), .ReadDataW(ReadDataW), .ALUResultW(ALUResultW),
    .RdW(RdW), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic wexp_t mkW(input logic rs, rw, frw,
                                input logic [31:0] rdat, alu,
                                input logic [4:0] rd);
    wexp_t e;
    e.rs = rs; e.rw = rw; e.frw = frw; e.rdat = rdat; e.alu = alu; e.rd = rd;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setM(input logic rs, rw, frw, mw,
                      input logic [31:0] alu, wd,
                      input logic [4:0] rd,
                      input logic rdy,
                      input logic [31:0] rdata);
    ResultSrcM = rs; RegWriteM = rw; FRegWriteM = frw; MemWriteM = mw;
    ALUResultM = alu; WriteDataM = wd; RdM = rd;
    mem_ready = rdy; mem_rdata = rdata;
  endtask

  task automatic chkW(input wexp_t e);
    chk("ResultSrcW", 32'(ResultSrcW), 32'(e.rs));
    chk("RegWriteW",  32'(RegWriteW),  32'(e.rw));
    chk("FRegWriteW", 32'(FRegWriteW), 32'(e.frw));
    chk("ReadDataW",  ReadDataW,       e.rdat);
    chk("ALUResultW", ALUResultW,      e.alu);
    chk("RdW",        32'(RdW),        32'(e.rd));
  endtask

  // One pipeline cycle with the current inputs.
  task automatic cycle(input wexp_t e, input logic eReq, eStall,
                       input logic [31:0] eAddr, input logic eWe,
                       input logic [31:0] eWd);
    wexp_t g;
    sb.push_back(e);
    @(posedge clk);
    chk("mem_req", 32'(mem_req), 32'(eReq));
    chk("StallM",  32'(StallM),  32'(eStall));
    if (eReq) begin
      chk("mem_addr", mem_addr, eAddr);
      chk("mem_we",   32'(mem_we), 32'(eWe));
      if (eWe) chk("mem_wdata", mem_wdata, eWd);
    end
    @(negedge clk); #1;
    g = sb.pop_front();
    chkW(g);
  endtask

  initial begin
    reset = 1'b0;
    setM(1, 1, 0, 0, 32'h40, 0, 5'd3, 0, 0);
    #3;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_StallM",  32'(StallM), 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    chkW(BUB);
    #9 reset = 1'b1;

    // CLEAR edge: load present but no request yet; request on the next cycle
    cycle(BUB, 0, 0, 0, 0, 0);
    cycle(BUB, 1, 1, 32'h40, 0, 0);
    setM(1, 1, 0, 0, 32'h40, 0, 5'd3, 1, 32'h11);
    cycle(mkW(1, 1, 0, 32'h11, 32'h40, 5'd3), 1, 0, 32'h40, 0, 0);

    // ALU ops: direct capture, no stall; stray ready ignored
    setM(0, 1, 0, 0, 32'h1234, 0, 5'd5, 0, 0);
    cycle(mkW(0, 1, 0, 0, 32'h1234, 5'd5), 0, 0, 0, 0, 0);
    setM(0, 1, 0, 0, 32'h77, 0, 5'd7, 1, 32'hBAD0BAD0);
    cycle(mkW(0, 1, 0, 0, 32'h77, 5'd7), 0, 0, 0, 0, 0);
    setM(0, 0, 1, 0, 32'h88, 0, 5'd9, 0, 0);
    cycle(mkW(0, 0, 1, 0, 32'h88, 5'd9), 0, 0, 0, 0, 0);

    // Load at 0x100 with 3 stall cycles; M inputs scrambled while waiting
    setM(1, 1, 0, 0, 32'h100, 0, 5'd10, 0, 0);
    cycle(BUB, 1, 1, 32'h100, 0, 0);
    setM(1, 1, 0, 0, 32'h999, 0, 5'd11, 0, 0);
    cycle(BUB, 1, 1, 32'h100, 0, 0);
    cycle(BUB, 1, 1, 32'h100, 0, 0);
    setM(1, 1, 0, 0, 32'h999, 0, 5'd11, 1, 32'hDEADBEEF);
    cycle(mkW(1, 1, 0, 32'hDEADBEEF, 32'h100, 5'd10), 1, 0, 32'h100, 0, 0);

    // Zero-wait store, then back-to-back zero-wait load, then idle
    setM(0, 0, 0, 1, 32'h200, 32'hCAFEF00D, 5'd0, 1, 32'h1111);
    cycle(mkW(0, 0, 0, 0, 32'h200, 5'd0), 1, 0, 32'h200, 1, 32'hCAFEF00D);
    setM(1, 1, 0, 0, 32'h204, 0, 5'd12, 1, 32'hA5A5A5A5);
    cycle(mkW(1, 1, 0, 32'hA5A5A5A5, 32'h204, 5'd12), 1, 0, 32'h204, 0, 0);
    setM(0, 0, 0, 0, 32'h5, 0, 5'd0, 0, 0);
    cycle(mkW(0, 0, 0, 0, 32'h5, 5'd0), 0, 0, 0, 0, 0);

    // Timeout: 1 IDLE stall + 15 WAIT stalls, then abandon cycle
    setM(1, 1, 0, 0, 32'h300, 0, 5'd13, 0, 0);
    chk("err_before", 32'(mem_err), 0);
    cycle(BUB, 1, 1, 32'h300, 0, 0);
    for (int i = 0; i < 15; i++) cycle(BUB, 1, 1, 32'h300, 0, 0);
    cycle(BUB, 0, 0, 0, 0, 0);
    chk("err_set", 32'(mem_err), 1);
    setM(0, 1, 0, 0, 32'h42, 0, 5'd14, 0, 0);
    cycle(mkW(0, 1, 0, 0, 32'h42, 5'd14), 0, 0, 0, 0, 0);
    chk("err_sticky", 32'(mem_err), 1);

    // Reset in the second WAIT cycle
    setM(1, 1, 0, 0, 32'h400, 0, 5'd15, 0, 0);
    cycle(BUB, 1, 1, 32'h400, 0, 0);
    cycle(BUB, 1, 1, 32'h400, 0, 0);
    @(posedge clk);
    chk("wait2_req", 32'(mem_req), 1);
    #1 reset = 1'b0;
    #1;
    chk("rstw_mem_req", 32'(mem_req), 0);
    chk("rstw_StallM",  32'(StallM), 0);
    chk("rstw_mem_err", 32'(mem_err), 0);
    @(negedge clk); #1;
    reset = 1'b1;
    cycle(BUB, 0, 0, 0, 0, 0);
    cycle(BUB, 1, 1, 32'h400, 0, 0);
    setM(1, 1, 0, 0, 32'h400, 0, 5'd15, 1, 32'h12345678);
    cycle(mkW(1, 1, 0, 32'h12345678, 32'h400, 5'd15), 1, 0, 32'h400, 0, 0);
    chk("err_after_rst", 32'(mem_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
